// File: rtl/env_rate_shift_gen_if.sv
// Slot-side bus of the envelope rate/shift generator: per-slot operator controls in,
// clipped rate, envelope shift and EG timer debug values out.
interface env_rate_shift_gen_if #(
  parameter int NUM_BANKS       = 2,
  parameter int OPS_PER_BANK    = 18,
  parameter int EG_TIMER_WIDTH  = 13,
  parameter int ENV_SHIFT_WIDTH = 2
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int OP_W   = (OPS_PER_BANK > 1) ? $clog2(OPS_PER_BANK) : 1;

  logic                       sample_clk_en;
  logic [BANK_W-1:0]          bank_num;
  logic [OP_W-1:0]            op_num;
  logic                       ksr;
  logic                       nts;
  logic [9:0]                 fnum;
  logic [2:0]                 block;
  logic [3:0]                 requested_rate_p0;
  logic                       timer_hold;
  logic                       timer_clear;
  logic [3:0]                 rate_hi_p2;
  logic [ENV_SHIFT_WIDTH-1:0] env_shift_p2;
  logic                       valid_p2;
  logic                       eg_state_o;
  logic [EG_TIMER_WIDTH-1:0]  eg_timer_o;

  modport master (
    output sample_clk_en, bank_num, op_num, ksr, nts, fnum, block,
           requested_rate_p0, timer_hold, timer_clear,
    input  rate_hi_p2, env_shift_p2, valid_p2, eg_state_o, eg_timer_o
  );

  modport slave (
    input  sample_clk_en, bank_num, op_num, ksr, nts, fnum, block,
           requested_rate_p0, timer_hold, timer_clear,
    output rate_hi_p2, env_shift_p2, valid_p2, eg_state_o, eg_timer_o
  );
endinterface

// File: rtl/env_rate_shift_gen.sv
// OPL envelope rate/shift generator: two-stage slot pipeline producing the clipped
// effective rate and envelope shift, driven by a global EG timer stepped once per sample.
module env_rate_shift_gen #(
  parameter int NUM_BANKS       = 2,
  parameter int OPS_PER_BANK    = 18,
  parameter int EG_TIMER_WIDTH  = 13,
  parameter int TICK_DELAY      = 3,
  parameter int ENV_SHIFT_WIDTH = 2
) (
  input logic                clk,
  input logic                reset,
  env_rate_shift_gen_if.slave bus
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int OP_W   = (OPS_PER_BANK > 1) ? $clog2(OPS_PER_BANK) : 1;
  localparam int ADD_W  = $clog2(EG_TIMER_WIDTH + 1);
  localparam int SH_W   = ((ADD_W > 4) ? ADD_W : 4) + 1;

  // rate is 7 bits wide so that ks + (req<<2) up to 75 reaches the clip intact
  function automatic logic [3:0] clip_rate_hi(input logic [6:0] rate);
    return (rate[6:2] > 5'd15) ? 4'd15 : rate[5:2];
  endfunction

  function automatic logic step_bit(input logic [1:0] lo, input logic [1:0] t);
    case (lo)
      2'd0:    step_bit = 1'b0;
      2'd1:    step_bit = (t == 2'd0);
      2'd2:    step_bit = ~t[0];
      default: step_bit = (t != 2'd3);
    endcase
  endfunction

  function automatic logic [1:0] env_shift_calc(
    input logic            nz,
    input logic [3:0]      hi,
    input logic [1:0]      lo,
    input logic [SH_W-1:0] sh,
    input logic            state,
    input logic [1:0]      t
  );
    logic [2:0] pre;
    pre = {1'b0, hi[1:0]} + {2'b00, step_bit(lo, t)};
    if (!nz) return 2'd0;
    if (hi < 4'd12) begin
      if (!state) return 2'd0;
      if (sh == SH_W'(12)) return 2'd1;
      if (sh == SH_W'(13)) return {1'b0, lo[1]};
      if (sh == SH_W'(14)) return {1'b0, lo[0]};
      return 2'd0;
    end
    if (pre[2]) return 2'd3;
    if (pre == 3'd0) return {1'b0, state};
    return pre[1:0];
  endfunction

  function automatic logic [ADD_W-1:0] trailing_zeros(input logic [EG_TIMER_WIDTH-1:0] v);
    logic [ADD_W-1:0] n;
    logic             seen;
    n    = '0;
    seen = 1'b0;
    for (int i = 0; i < EG_TIMER_WIDTH; i++) begin
      if (!seen) begin
        if (v[i]) seen = 1'b1;
        else      n = n + ADD_W'(1);
      end
    end
    return n;
  endfunction

  logic                       eg_state;
  logic [EG_TIMER_WIDTH-1:0]  eg_timer;
  logic [ADD_W-1:0]           eg_add;
  logic [1:0]                 eg_timer_lo;
  logic                       eg_state_nxt;
  logic [EG_TIMER_WIDTH-1:0]  eg_timer_nxt;
  logic [ADD_W-1:0]           eg_add_nxt;
  logic [1:0]                 eg_timer_lo_nxt;

  logic [TICK_DELAY-1:0]      en_dly;
  logic [BANK_W-1:0]          bank_dly [TICK_DELAY];
  logic [OP_W-1:0]            op_dly   [TICK_DELAY];
  logic                       tick;

  logic [3:0]                 ksv_p0;
  logic [3:0]                 ks_p0;
  logic [6:0]                 rate_p0;
  logic [6:0]                 rate_p1;
  logic                       nz_p1;
  logic                       vld_p1;
  logic [3:0]                 hi_p1;
  logic [1:0]                 lo_p1;
  logic [SH_W-1:0]            sh_p1;
  logic [1:0]                 shift_p1;
  logic [3:0]                 rate_hi_p2;
  logic [ENV_SHIFT_WIDTH-1:0] env_shift_p2;
  logic                       vld_p2;

  logic                       unused_fnum;
  assign unused_fnum = ^bus.fnum[7:0];

  // p0: key-scale value and raw effective rate
  assign ksv_p0  = {bus.block, bus.nts ? bus.fnum[8] : bus.fnum[9]};
  assign ks_p0   = bus.ksr ? ksv_p0 : (ksv_p0 >> 2);
  assign rate_p0 = {3'b000, ks_p0} + {1'b0, bus.requested_rate_p0, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_p1 <= '0;
      nz_p1   <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      rate_p1 <= rate_p0;
      nz_p1   <= (bus.requested_rate_p0 != 4'd0);
      vld_p1  <= bus.sample_clk_en;
    end
  end

  // p1: clip, shift selection against the live EG timer state
  assign hi_p1    = clip_rate_hi(rate_p1);
  assign lo_p1    = rate_p1[1:0];
  assign sh_p1    = SH_W'(hi_p1) + SH_W'(eg_add);
  assign shift_p1 = env_shift_calc(nz_p1, hi_p1, lo_p1, sh_p1, eg_state, eg_timer_lo);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_hi_p2   <= '0;
      env_shift_p2 <= '0;
      vld_p2       <= 1'b0;
    end else begin
      rate_hi_p2   <= hi_p1;
      env_shift_p2 <= ENV_SHIFT_WIDTH'(shift_p1);
      vld_p2       <= vld_p1;
    end
  end

  // p2: registered outputs
  assign bus.rate_hi_p2   = rate_hi_p2;
  assign bus.env_shift_p2 = env_shift_p2;
  assign bus.valid_p2     = vld_p2;
  assign bus.eg_state_o   = eg_state;
  assign bus.eg_timer_o   = eg_timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_dly <= '0;
      for (int i = 0; i < TICK_DELAY; i++) begin
        bank_dly[i] <= '0;
        op_dly[i]   <= '0;
      end
    end else begin
      en_dly[0]   <= bus.sample_clk_en;
      bank_dly[0] <= bus.bank_num;
      op_dly[0]   <= bus.op_num;
      for (int i = 1; i < TICK_DELAY; i++) begin
        en_dly[i]   <= en_dly[i-1];
        bank_dly[i] <= bank_dly[i-1];
        op_dly[i]   <= op_dly[i-1];
      end
    end
  end

  // End of sample: the last operator of the last bank, seen after the delay line
  assign tick = en_dly[TICK_DELAY-1]
             && (bank_dly[TICK_DELAY-1] == BANK_W'(NUM_BANKS - 1))
             && (op_dly[TICK_DELAY-1] == OP_W'(OPS_PER_BANK - 1));

  always_comb begin
    eg_state_nxt    = eg_state;
    eg_timer_nxt    = eg_timer;
    eg_add_nxt      = eg_add;
    eg_timer_lo_nxt = eg_timer_lo;
    if (bus.timer_clear) begin
      eg_state_nxt    = 1'b0;
      eg_timer_nxt    = '0;
      eg_add_nxt      = '0;
      eg_timer_lo_nxt = '0;
    end else if (!bus.timer_hold && tick) begin
      eg_state_nxt = ~eg_state;
      if (eg_state) begin
        eg_add_nxt      = (eg_timer == '0) ? '0 : trailing_zeros(eg_timer) + ADD_W'(1);
        eg_timer_nxt    = eg_timer + EG_TIMER_WIDTH'(1);
        eg_timer_lo_nxt = eg_timer[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eg_state    <= 1'b0;
      eg_timer    <= '0;
      eg_add      <= '0;
      eg_timer_lo <= '0;
    end else begin
      eg_state    <= eg_state_nxt;
      eg_timer    <= eg_timer_nxt;
      eg_add      <= eg_add_nxt;
      eg_timer_lo <= eg_timer_lo_nxt;
    end
  end

endmodule

// File: tb/tb_env_rate_shift_gen.sv
// Scoreboard bench for env_rate_shift_gen with a small 4-bit EG timer and 2x3 operator slots;
// EG state is stepped by explicit end-of-sample slots and tracked by hand in the vectors.
module tb_env_rate_shift_gen;
  localparam int NB  = 2;
  localparam int OPB = 3;
  localparam int TW  = 4;
  localparam int TD  = 3;
  localparam int ESW = 2;
  localparam int BW  = $clog2(NB);
  localparam int OW  = $clog2(OPB);

  typedef struct {
    logic [3:0]     hi;
    logic [ESW-1:0] sh;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  env_rate_shift_gen_if #(.NUM_BANKS(NB), .OPS_PER_BANK(OPB), .EG_TIMER_WIDTH(TW),
                          .ENV_SHIFT_WIDTH(ESW)) bus ();

  env_rate_shift_gen #(.NUM_BANKS(NB), .OPS_PER_BANK(OPB), .EG_TIMER_WIDTH(TW),
                       .TICK_DELAY(TD), .ENV_SHIFT_WIDTH(ESW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented result is matched against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && bus.valid_p2) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("rate_hi_p2", int'(bus.rate_hi_p2), int'(e.hi));
        chk("env_shift_p2", int'(bus.env_shift_p2), int'(e.sh));
        chk("valid_latency", cyc, e.cyc + 2);
      end
    end
  end

  task automatic slot(input int bank, input int op, input int ksr, input int nts,
                      input int fnum, input int blk, input int req,
                      input int ehi, input int esh);
    exp_t e;
    @(negedge clk);
    bus.sample_clk_en     = 1'b1;
    bus.bank_num          = BW'(bank);
    bus.op_num            = OW'(op);
    bus.ksr               = ksr[0];
    bus.nts               = nts[0];
    bus.fnum              = 10'(fnum);
    bus.block             = 3'(blk);
    bus.requested_rate_p0 = 4'(req);
    e.hi  = 4'(ehi);
    e.sh  = ESW'(esh);
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic data(input int ksr, input int nts, input int fnum, input int blk,
                      input int req, input int ehi, input int esh);
    slot(0, 0, ksr, nts, fnum, blk, req, ehi, esh);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.sample_clk_en = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic tick_slot();
    slot(NB - 1, OPB - 1, 0, 0, 0, 0, 0, 0, 0);
    idle(6);
  endtask

  task automatic chk_eg(input string name, input int st, input int tmr);
    chk({name, "_eg_state"}, int'(bus.eg_state_o), st);
    chk({name, "_eg_timer"}, int'(bus.eg_timer_o), tmr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.sample_clk_en = 1'b0; bus.bank_num = '0; bus.op_num = '0;
    bus.ksr = 1'b0; bus.nts = 1'b0; bus.fnum = '0; bus.block = '0;
    bus.requested_rate_p0 = '0; bus.timer_hold = 1'b0; bus.timer_clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(bus.valid_p2), 0);
    chk("rst_rate_hi", int'(bus.rate_hi_p2), 0);
    chk("rst_shift", int'(bus.env_shift_p2), 0);
    chk_eg("rst", 0, 0);
    reset = 1'b0;

    // eg_state=0, eg_add=0, timer_lo=0; zero rate and basic key scaling
    data(1, 0, 'h200, 5, 0, 2, 0);
    data(0, 0, 'h3FF, 7, 0, 0, 0);
    data(1, 0, 'h200, 7, 15, 15, 3);
    data(0, 0, 0, 0, 12, 12, 0);
    data(1, 0, 'h200, 0, 12, 12, 1);
    data(1, 1, 'h100, 0, 12, 12, 1);
    data(0, 0, 0, 0, 13, 13, 1);
    data(0, 0, 0, 0, 9, 9, 0);
    idle(4);

    tick_slot();                        // state 1, timer 0
    chk_eg("tick1", 1, 0);
    data(0, 0, 0, 0, 12, 12, 1);
    data(0, 0, 0, 0, 9, 9, 0);
    data(1, 0, 'h200, 0, 12, 12, 1);
    idle(3);
    tick_slot();                        // state 0, timer 1, add 0, lo 0
    data(0, 0, 0, 0, 12, 12, 0);
    idle(3);
    tick_slot();
    tick_slot();                        // state 0, timer 2, add 1, lo 1
    data(1, 0, 'h200, 7, 15, 15, 3);
    data(1, 0, 'h200, 0, 12, 12, 0);
    data(1, 0, 0, 1, 12, 12, 0);
    idle(3);
    tick_slot();                        // state 1
    data(1, 0, 0, 1, 12, 12, 1);
    idle(3);
    tick_slot();                        // state 0, timer 3, add 2, lo 2
    data(1, 0, 0, 1, 12, 12, 1);
    data(1, 0, 0, 1, 13, 13, 2);
    data(0, 0, 0, 0, 14, 14, 2);
    data(0, 0, 0, 0, 15, 15, 3);
    idle(3);
    tick_slot();
    tick_slot();                        // state 0, timer 4, add 1, lo 3
    data(1, 0, 'h200, 7, 15, 15, 3);
    data(1, 0, 'h200, 1, 12, 12, 0);
    data(1, 0, 'h200, 1, 14, 14, 2);
    idle(3);
    tick_slot();
    chk_eg("timer4", 1, 4);
    tick_slot();                        // state 0, timer 5, add 3, lo 0
    chk_eg("timer5", 0, 5);
    data(0, 0, 0, 0, 9, 9, 0);
    idle(3);
    tick_slot();                        // state 1, add 3
    data(0, 0, 0, 0, 9, 9, 1);
    data(0, 0, 0, 0, 10, 10, 0);
    data(1, 0, 0, 1, 10, 10, 1);
    data(1, 0, 'h200, 0, 11, 11, 1);
    data(0, 0, 0, 0, 11, 11, 0);
    data(0, 0, 0, 0, 8, 8, 0);
    data(1, 0, 'h200, 7, 0, 3, 0);
    idle(3);

    for (int i = 0; i < 20; i++) tick_slot();
    chk_eg("timer15", 1, 15);
    tick_slot();                        // wrap: state 0, timer 0, add 1
    chk_eg("wrap", 0, 0);
    tick_slot();
    data(0, 0, 0, 0, 11, 11, 1);
    idle(3);
    tick_slot();                        // add 0 from zero timer, timer 1
    chk_eg("post_wrap", 0, 1);
    tick_slot();
    data(0, 0, 0, 0, 11, 11, 0);
    idle(3);

    // slots that are not the last of the sample never tick
    slot(0, OPB - 1, 0, 0, 0, 0, 0, 0, 0);
    slot(NB - 1, OPB - 2, 0, 0, 0, 0, 0, 0, 0);
    slot(NB - 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(6);
    chk_eg("no_tick", 1, 1);

    bus.timer_hold = 1'b1;
    tick_slot();
    bus.timer_hold = 1'b0;
    repeat (4) @(negedge clk);
    chk_eg("hold", 1, 1);

    tick_slot();                        // state 0, timer 2, add 1, lo 1
    chk_eg("pre_clear", 0, 2);
    bus.timer_clear = 1'b1;
    bus.timer_hold  = 1'b1;
    @(negedge clk);
    bus.timer_clear = 1'b0;
    bus.timer_hold  = 1'b0;
    chk_eg("clear", 0, 0);
    data(1, 0, 0, 1, 12, 12, 1);
    idle(3);
    tick_slot();                        // state 1, add stays 0
    data(0, 0, 0, 0, 11, 11, 0);
    idle(3);
    tick_slot();
    tick_slot();                        // state 1, timer 1

    // asynchronous reset between clock edges with results in flight
    data(1, 0, 'h200, 7, 15, 15, 3);
    data(1, 0, 'h200, 7, 15, 15, 3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus.sample_clk_en = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.valid_p2), 0);
    chk("async_rst_rate_hi", int'(bus.rate_hi_p2), 0);
    chk("async_rst_shift", int'(bus.env_shift_p2), 0);
    chk_eg("async_rst", 0, 0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    data(0, 0, 0, 0, 12, 12, 0);
    data(1, 0, 'h200, 5, 0, 2, 0);
    idle(4);
    chk_eg("resume", 0, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("drain_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
